// File: rtl/calc_entry_if.sv
// rtl/calc_entry_if.sv - keypad-entry / ALU handshake bundle for calc_entry_ctrl
interface calc_entry_if #(
    parameter int NDIGITS = 4
);
    logic                   key_valid;
    logic [3:0]             key_code;
    logic                   calc_req;
    logic                   calc_ack;
    logic [4*NDIGITS-1:0]   op_a;
    logic [4*NDIGITS-1:0]   op_b;
    logic [1:0]             op_sel;
    logic [4*NDIGITS-1:0]   res_bcd;
    logic                   res_err;
    logic [4*NDIGITS-1:0]   disp_bcd;
    logic                   disp_err;
    logic                   busy;

    modport slave (
        input  key_valid, key_code, calc_ack, res_bcd, res_err,
        output calc_req, op_a, op_b, op_sel, disp_bcd, disp_err, busy
    );

    modport master (
        output key_valid, key_code, calc_ack, res_bcd, res_err,
        input  calc_req, op_a, op_b, op_sel, disp_bcd, disp_err, busy
    );
endinterface

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - keypad debounce and operand/operator entry FSM with ALU req/ack
// Optional: define CALC_CHAIN_EN to let an operator in SHOW continue from the result.
module calc_entry_ctrl #(
    parameter int NDIGITS   = 4,
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 5
) (
    input logic         CLK,
    input logic         RESET,
    calc_entry_if.slave bus
);
    localparam int W  = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(NDIGITS);
    localparam logic [3:0] K_CLEAR = 4'd10;
    localparam logic [3:0] K_EQ    = 4'd11;
    localparam logic [3:0] K_OP    = 4'd12;

    typedef enum logic [1:0] {ARMED, PRESS_CNT, WAIT_REL} db_state_t;
    typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} st_t;

    db_state_t       db_state, db_state_n;
    logic [DB_W-1:0] db_cnt, db_cnt_n;
    logic [3:0]      cand, cand_n;
    logic            ev, ev_n;

    st_t             state, state_n;
    logic [W-1:0]    op_a, op_a_n, op_b, op_b_n, result, result_n, disp_bcd;
    logic [1:0]      op_sel, op_sel_n;
    logic [CW-1:0]   cnt_a, cnt_a_n, cnt_b, cnt_b_n;
    logic            err, err_n, calc_req, calc_req_n, disp_err;
    logic            clear, load_digit;

    // cand stays stable in WAIT_REL, so it doubles as the event's key code.
    always_comb begin
        db_state_n = db_state;
        db_cnt_n   = db_cnt;
        cand_n     = cand;
        ev_n       = 1'b0;
        case (db_state)
            ARMED: if (bus.key_valid) begin
                cand_n     = bus.key_code;
                db_cnt_n   = DB_W'(1);
                db_state_n = PRESS_CNT;
            end
            PRESS_CNT: begin
                if (!bus.key_valid) begin
                    db_cnt_n   = '0;
                    db_state_n = ARMED;
                end else if (bus.key_code != cand) begin
                    cand_n   = bus.key_code;
                    db_cnt_n = DB_W'(1);
                end else if (db_cnt == DB_LAST) begin
                    ev_n       = 1'b1;
                    db_cnt_n   = '0;
                    db_state_n = WAIT_REL;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end
            WAIT_REL: begin
                if (bus.key_valid) begin
                    db_cnt_n = '0;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt_n   = '0;
                    db_state_n = ARMED;
                end else begin
                    db_cnt_n = db_cnt + 1'b1;
                end
            end
            default: db_state_n = ARMED;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            db_state <= ARMED;
            db_cnt   <= '0;
            cand     <= '0;
            ev       <= 1'b0;
        end else begin
            db_state <= db_state_n;
            db_cnt   <= db_cnt_n;
            cand     <= cand_n;
            ev       <= ev_n;
        end
    end

    always_comb begin
        state_n    = state;
        op_a_n     = op_a;
        op_b_n     = op_b;
        op_sel_n   = op_sel;
        cnt_a_n    = cnt_a;
        cnt_b_n    = cnt_b;
        result_n   = result;
        err_n      = err;
        calc_req_n = calc_req;
        clear      = 1'b0;
        load_digit = 1'b0;
        if (state == CALC && bus.calc_ack) begin
            result_n   = bus.res_bcd;
            err_n      = bus.res_err;
            calc_req_n = 1'b0;
            state_n    = SHOW;
        end
        if (ev) begin
            case (state)
                ENTER_A: begin
                    if (cand < K_CLEAR) begin
                        if (cnt_a < CNT_MAX) begin
                            op_a_n  = {op_a[W-5:0], cand};
                            cnt_a_n = cnt_a + 1'b1;
                        end
                    end else if (cand >= K_OP) begin
                        op_sel_n = cand[1:0];
                        op_b_n   = '0;
                        cnt_b_n  = '0;
                        state_n  = ENTER_B;
                    end else if (cand == K_CLEAR) begin
                        clear = 1'b1;
                    end
                end
                ENTER_B: begin
                    if (cand < K_CLEAR) begin
                        if (cnt_b < CNT_MAX) begin
                            op_b_n  = {op_b[W-5:0], cand};
                            cnt_b_n = cnt_b + 1'b1;
                        end
                    end else if (cand >= K_OP) begin
                        op_sel_n = cand[1:0];
                    end else if (cand == K_EQ) begin
                        calc_req_n = 1'b1;
                        state_n    = CALC;
                    end else begin
                        clear = 1'b1;
                    end
                end
                SHOW: begin
                    if (cand < K_CLEAR) begin
                        load_digit = 1'b1;
                    end else if (cand == K_CLEAR) begin
                        clear = 1'b1;
                    end
`ifdef CALC_CHAIN_EN
                    else if (cand >= K_OP && !err) begin
                        op_a_n   = result;
                        cnt_a_n  = CNT_MAX;
                        op_sel_n = cand[1:0];
                        op_b_n   = '0;
                        cnt_b_n  = '0;
                        state_n  = ENTER_B;
                    end
`endif
                end
                default: ;
            endcase
        end
        if (clear || load_digit) begin
            op_a_n     = '0;
            op_b_n     = '0;
            op_sel_n   = '0;
            cnt_a_n    = '0;
            cnt_b_n    = '0;
            result_n   = '0;
            err_n      = 1'b0;
            calc_req_n = 1'b0;
            state_n    = ENTER_A;
        end
        if (load_digit) begin
            op_a_n  = W'(cand);
            cnt_a_n = CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ENTER_A;
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            result   <= '0;
            err      <= 1'b0;
            calc_req <= 1'b0;
            disp_bcd <= '0;
            disp_err <= 1'b0;
        end else begin
            state    <= state_n;
            op_a     <= op_a_n;
            op_b     <= op_b_n;
            op_sel   <= op_sel_n;
            cnt_a    <= cnt_a_n;
            cnt_b    <= cnt_b_n;
            result   <= result_n;
            err      <= err_n;
            calc_req <= calc_req_n;
            // Display follows the current registers, so it lags any change by one cycle.
            case (state)
                ENTER_A: disp_bcd <= op_a;
                ENTER_B: disp_bcd <= (cnt_b != '0) ? op_b : op_a;
                CALC:    disp_bcd <= op_b;
                default: disp_bcd <= result;
            endcase
            disp_err <= (state == SHOW) && err;
        end
    end

    assign bus.calc_req = calc_req;
    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;
    assign bus.op_sel   = op_sel;
    assign bus.disp_bcd = disp_bcd;
    assign bus.disp_err = disp_err;
    assign bus.busy     = (state == CALC);
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - scoreboard bench for calc_entry_ctrl with randomized key sequences
module tb_calc_entry_ctrl;
    localparam int ND = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    calc_entry_if #(.NDIGITS(ND)) bus ();

    calc_entry_ctrl #(.NDIGITS(ND), .DB_CYCLES(16), .DB_W(5)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {logic [15:0] a; logic [15:0] b; logic [1:0] sel;} req_t;
    typedef struct {
        logic [15:0] a; logic [15:0] b; logic [15:0] disp; logic [1:0] sel;
        logic derr; logic busy; logic req;
    } snap_t;
    req_t  req_q[$];
    snap_t snap_q[$];

    // Reference calculator: mode 0 entering A, 1 entering B, 2 waiting on ALU, 3 showing result
    logic [15:0] m_a, m_b, m_res;
    logic [1:0]  m_sel;
    logic        m_err;
    int          m_ca, m_cb, m_mode;
    logic [15:0] alu_res = '0;
    logic        alu_err = 1'b0;
    logic        ack_hold = 1'b0;

    task automatic model_clear();
        m_a = 0; m_b = 0; m_res = 0; m_sel = 0; m_err = 0;
        m_ca = 0; m_cb = 0; m_mode = 0;
    endtask

    task automatic model_ack();
        m_res = alu_res; m_err = alu_err; m_mode = 3;
    endtask

    task automatic model_key(input int code);
        if (m_mode == 2) return;
        if (code < 10) begin
            if (m_mode == 3) begin
                model_clear();
                m_a = 16'(code); m_ca = 1;
            end else if (m_mode == 0) begin
                if (m_ca < ND) begin m_a = 16'(m_a * 16 + code); m_ca++; end
            end else begin
                if (m_cb < ND) begin m_b = 16'(m_b * 16 + code); m_cb++; end
            end
        end else if (code == 10) begin
            model_clear();
        end else if (code == 11) begin
            if (m_mode == 1) begin
                req_q.push_back('{m_a, m_b, m_sel});
                if (ack_hold) m_mode = 2;
                else model_ack();
            end
        end else begin
            if (m_mode == 0) begin
                m_sel = 2'(code - 12); m_b = 0; m_cb = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                m_sel = 2'(code - 12);
            end else begin
`ifdef CALC_CHAIN_EN
                if (!m_err) begin
                    m_a = m_res; m_ca = ND; m_sel = 2'(code - 12);
                    m_b = 0; m_cb = 0; m_mode = 1;
                end
`endif
            end
        end
    endtask

    task automatic push_snap();
        logic [15:0] d;
        case (m_mode)
            0:       d = m_a;
            1:       d = (m_cb > 0) ? m_b : m_a;
            2:       d = m_b;
            default: d = m_res;
        endcase
        snap_q.push_back('{m_a, m_b, d, m_sel, (m_mode == 3) ? m_err : 1'b0,
                           m_mode == 2, m_mode == 2});
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v = '0;
        for (int i = 0; i < 4; i++) v = {v[11:0], 4'($urandom_range(0, 9))};
        return v;
    endfunction

    task automatic press(input int code, input int hi, input int lo);
        model_key(code);
        @(negedge CLK);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'(code);
        repeat (hi) @(negedge CLK);
        bus.key_valid = 1'b0;
        repeat (lo) @(negedge CLK);
        push_snap();
    endtask

    task automatic seq(input int codes[$]);
        foreach (codes[i]) press(codes[i], 18, 18);
    endtask

    // ALU stand-in: random latency, ack either one cycle or held until calc_req falls
    initial begin
        bus.calc_ack = 1'b0;
        bus.res_bcd  = '0;
        bus.res_err  = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.calc_req && !ack_hold && !RESET) begin
                repeat ($urandom_range(0, 5)) @(negedge CLK);
                if (bus.calc_req && !ack_hold && !RESET) begin
                    bus.res_bcd  = alu_res;
                    bus.res_err  = alu_err;
                    bus.calc_ack = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        for (int t = 0; t < 20 && bus.calc_req; t++) @(negedge CLK);
                    end else begin
                        @(negedge CLK);
                    end
                    bus.calc_ack = 1'b0;
                    bus.res_bcd  = rand_bcd();
                    bus.res_err  = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: checks operands when a compute request appears, and state snapshots
    logic prev_req = 1'b0;
    always @(negedge CLK) begin
        if (bus.calc_req && !prev_req) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                req_t r;
                r = req_q.pop_front();
                chk("req_op_a", bus.op_a, r.a);
                chk("req_op_b", bus.op_b, r.b);
                chk("req_op_sel", bus.op_sel, r.sel);
            end
        end
        prev_req = bus.calc_req;
        if (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            chk("op_a", bus.op_a, s.a);
            chk("op_b", bus.op_b, s.b);
            chk("op_sel", bus.op_sel, s.sel);
            chk("disp_bcd", bus.disp_bcd, s.disp);
            chk("disp_err", bus.disp_err, s.derr);
            chk("busy", bus.busy, s.busy);
            chk("calc_req", bus.calc_req, s.req);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        model_clear();
        repeat (3) @(negedge CLK);
        chk("rst_calc_req", bus.calc_req, 0);
        chk("rst_op_a", bus.op_a, 0);
        chk("rst_disp", bus.disp_bcd, 0);
        chk("rst_busy", bus.busy, 0);
        RESET = 1'b0;
        push_snap();

        // One cycle short of the debounce window: no event
        @(negedge CLK);
        bus.key_valid = 1'b1; bus.key_code = 4'd5;
        repeat (15) @(negedge CLK);
        bus.key_valid = 1'b0;
        repeat (20) @(negedge CLK);
        push_snap();

        // Exact event latency, then a long hold yields a single digit
        model_key(5);
        @(negedge CLK);
        bus.key_valid = 1'b1; bus.key_code = 4'd5;
        repeat (16) @(negedge CLK);
        chk("op_a_cycle16", bus.op_a, 0);
        @(negedge CLK);
        chk("op_a_cycle17", bus.op_a, 16'h0005);
        repeat (100) @(negedge CLK);
        bus.key_valid = 1'b0;
        repeat (20) @(negedge CLK);
        push_snap();

        // Press bounce and release bounce: one digit 7
        model_key(7);
        @(negedge CLK);
        bus.key_valid = 1'b1; bus.key_code = 4'd7;
        repeat (10) @(negedge CLK);
        bus.key_valid = 1'b0;
        repeat (3) @(negedge CLK);
        bus.key_valid = 1'b1;
        repeat (16) @(negedge CLK);
        bus.key_valid = 1'b0;
        repeat (5) @(negedge CLK);
        bus.key_valid = 1'b1;
        repeat (2) @(negedge CLK);
        bus.key_valid = 1'b0;
        repeat (20) @(negedge CLK);
        push_snap();

        // Full entry 12 + 3 = 15
        alu_res = 16'h0015; alu_err = 1'b0;
        seq('{10, 1, 2, 12, 3, 11});

        // Entry overflow, then clear
        seq('{10, 1, 2, 3, 4, 5, 10});

        // Ack withheld while CLEAR and 9 are pressed; error result
        ack_hold = 1'b1;
        seq('{4, 14, 6, 11, 10, 9});
        repeat (50) @(negedge CLK);
        push_snap();
        alu_res = 16'h0042; alu_err = 1'b1;
        ack_hold = 1'b0;
        model_ack();
        repeat (30) @(negedge CLK);
        push_snap();
        seq('{13});

        // Chaining from a result (ignored when the chain option is absent)
        alu_res = 16'h0015; alu_err = 1'b0;
        seq('{10, 1, 2, 12, 3, 11});
        alu_res = 16'h0010;
        seq('{13, 5, 11});

        // Asynchronous reset in the middle of a computation
        ack_hold = 1'b1;
        seq('{10, 1, 12, 2, 11});
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("midcalc_rst_req", bus.calc_req, 0);
        chk("midcalc_rst_busy", bus.busy, 0);
        @(negedge CLK);
        RESET = 1'b0;
        ack_hold = 1'b0;
        model_clear();
        push_snap();
        seq('{8});

        // Randomized key sequences
        for (int i = 0; i < 60; i++) begin
            int r, code;
            r = $urandom_range(0, 99);
            if (r < 55)      code = $urandom_range(0, 9);
            else if (r < 75) code = $urandom_range(12, 15);
            else if (r < 90) code = 11;
            else             code = 10;
            alu_res = rand_bcd();
            alu_err = ($urandom_range(0, 3) == 0);
            press(code, $urandom_range(16, 22), $urandom_range(16, 22));
        end

        repeat (5) @(negedge CLK);
        chk("req_q_drained", req_q.size(), 0);
        chk("snap_q_drained", snap_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
Sequences keypad input for the calculator. Takes the raw level-type key indication and 4-bit key code from the keypad scanner, then debounces them into single key events. An operand/operator entry FSM assembles BCD operands A and B and an operator, and issues a compute request to the arithmetic unit with a req/ack handshake. Sits between the keypad scanner and the ALU/display path in the top level.

Parameters:
NDIGITS, 4, BCD digits per operand/result (register width 4*NDIGITS)
DB_CYCLES, 16, consecutive stable CLK cycles required for press and for release
DB_W, 5, debounce counter width (must hold DB_CYCLES)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-high reset
key_valid  in  1  scanner key-pressed level (high while a key is down)
key_code  in  4  scanner code: 0-9 digit, 10 CLEAR, 11 EQUALS, 12 ADD, 13 SUB, 14 MUL, 15 DIV
calc_req  out  1  compute request to ALU
calc_ack  in  1  ALU completion, single-cycle or held
op_a  out  4*NDIGITS  operand A, BCD, most-significant digit at top
op_b  out  4*NDIGITS  operand B, BCD
op_sel  out  2  operator: 0 ADD, 1 SUB, 2 MUL, 3 DIV
res_bcd  in  4*NDIGITS  ALU result, valid when calc_ack=1
res_err  in  1  ALU error (overflow, divide by zero), valid when calc_ack=1
disp_bcd  out  4*NDIGITS  value to show on display
disp_err  out  1  error indicator for display
busy  out  1  high in CALC state

Behaviour:
- Reset (RESET=1, async): op_a=op_b=0, op_sel=0, calc_req=0, disp_bcd=0, disp_err=0, busy=0, result reg=0, digit counts=0, FSM=ENTER_A, debouncer in ARMED with counter=0.
- Debouncer states: ARMED, PRESS_CNT, WAIT_REL.
  - ARMED: key_valid=1 samples key_code into cand, counter=1, go to PRESS_CNT.
  - PRESS_CNT: key_valid=1 with same code increments counter. Code change reloads cand with counter=1. key_valid=0 returns to ARMED.
  - When counter reaches DB_CYCLES: one-cycle internal event with cand, go to WAIT_REL. The event fires DB_CYCLES cycles after the first high sample.
  - WAIT_REL: needs DB_CYCLES consecutive key_valid=0 cycles to return to ARMED. Any high sample restarts the count. Exactly one event per physical press.
- Entry FSM states: ENTER_A, ENTER_B, CALC, SHOW. Acts only on debounced events.
  - ENTER_A:
    - digit: if cnt_a<NDIGITS, op_a <= {op_a shifted left 4, digit} and cnt_a++. Otherwise ignored; no wrap.
    - operator: op_sel latched, op_b=0, cnt_b=0, go to ENTER_B.
    - EQUALS: ignored.
    - CLEAR: full clear, equivalent to reset except the debouncer.
  - ENTER_B:
    - digit: shifts into op_b under the same NDIGITS rule.
    - operator: replaces op_sel, stays in ENTER_B.
    - EQUALS: calc_req=1 on the next cycle, go to CALC.
    - CLEAR: full clear.
  - CALC:
    - busy=1. calc_req stays high until calc_ack is sampled high.
    - On the ack edge: result <= res_bcd, err <= res_err, calc_req <= 0, go to SHOW.
    - All key events are dropped, including CLEAR. calc_req never drops before ack.
  - SHOW:
    - digit: full clear, then op_a=digit, cnt_a=1, go to ENTER_A.
    - CLEAR: full clear.
    - operator: see CHAIN_EN.
    - EQUALS: ignored.
- Display, registered and updated the cycle after a state or register change:
  - ENTER_A: op_a.
  - ENTER_B: op_b if cnt_b>0, else op_a.
  - CALC: op_b.
  - SHOW: result.
  - disp_err = err only in SHOW, 0 elsewhere.
- A key event coinciding with the calc_ack cycle is dropped, because the FSM is still in CALC.
- op_a, op_b and op_sel are stable throughout CALC.

Optional Feature:
CALC_CHAIN_EN
- Defined: in SHOW, an operator event with err=0 loads op_a=result and cnt_a=NDIGITS, latches op_sel, clears op_b, and goes to ENTER_B. With err=1 the operator is ignored.
- Undefined: operators in SHOW are ignored; only a digit or CLEAR leaves SHOW.

Test Plan:
- Debounce: key_valid=1 with code 5 for DB_CYCLES-1 cycles then released -> no event, op_a=0. Held 16 cycles -> op_a=0x0005 at cycle 17; key held 100 more cycles -> still one event.
- Bounce: code 7 for 10 cycles, 0 for 3 cycles, then 7 for 16 cycles -> exactly one digit 7 accepted. Release bouncing in WAIT_REL produces no second event.
- Full entry: keys 1,2,ADD,3,EQUALS -> op_a=0x0012, op_b=0x0003, op_sel=0, calc_req rises. ack with res_bcd=0x0015 after 5 cycles -> calc_req low, disp_bcd=0x0015, busy=0.
- Overflow of entry: digits 1,2,3,4,5 with NDIGITS=4 -> op_a=0x1234, fifth digit ignored. CLEAR -> op_a=0, FSM in ENTER_A.
- Handshake hold: ack withheld 50 cycles while keys CLEAR and 9 are pressed -> calc_req held high, op_a, op_b and op_sel unchanged. res_err=1 on ack -> disp_err=1.
- Chain (CALC_CHAIN_EN) / reset: in SHOW with result 0x0015, SUB then 5 then EQUALS -> op_a=0x0015, op_b=0x0005, op_sel=1. Macro off: SUB ignored. RESET asserted mid-CALC -> calc_req=0 immediately, FSM in ENTER_A.
